// File: rtl/gpio_input_bank.sv
// Input-conditioning bank: per-channel synchroniser, debounce filter and
// edge detection with sticky event flags feeding one level interrupt.

module gpio_input_chan #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   DEBOUNCE_BITS = 16,
    parameter logic RESET_BIT     = 1'b0
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     pin,
    input  logic [DEBOUNCE_BITS-1:0] limit,
    input  logic                     rise_en,
    input  logic                     fall_en,
    input  logic                     clr,
    output logic                     level,
    output logic                     flag
);
    logic [SYNC_STAGES-1:0]   sync;
    logic [DEBOUNCE_BITS-1:0] cnt;
    logic                     sync_q;
    logic                     differs;
    logic                     update;
    logic                     set;

    assign sync_q  = sync[SYNC_STAGES-1];
    assign differs = sync_q != level;
    // >= so a lowered limit takes effect on a count already in flight
    assign update  = differs && (cnt >= limit);
    assign set     = update && (sync_q ? rise_en : fall_en);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync  <= {SYNC_STAGES{RESET_BIT}};
            level <= RESET_BIT;
            cnt   <= '0;
            flag  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            if (!differs || update)
                cnt <= '0;
            else
                cnt <= cnt + DEBOUNCE_BITS'(1);
            if (update)
                level <= sync_q;
            // a set in the same cycle as a clear wins
            flag <= set | (flag & ~clr);
        end
    end
endmodule

module gpio_input_bank #(
    parameter int                  CHANNELS      = 8,
    parameter int                  SYNC_STAGES   = 2,
    parameter int                  DEBOUNCE_BITS = 16,
    parameter logic [CHANNELS-1:0] RESET_LEVEL   = '0
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [CHANNELS-1:0]      pin_in,
    input  logic [DEBOUNCE_BITS-1:0] debounce_limit,
    input  logic [CHANNELS-1:0]      rise_en,
    input  logic [CHANNELS-1:0]      fall_en,
    input  logic                     clr_valid,
    input  logic [CHANNELS-1:0]      clr_mask,
    output logic [CHANNELS-1:0]      level_out,
    output logic [CHANNELS-1:0]      event_flags,
    output logic                     irq
);
    logic [CHANNELS-1:0] clr;

    assign clr = clr_valid ? clr_mask : '0;
    assign irq = |event_flags;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        gpio_input_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_BITS(DEBOUNCE_BITS),
            .RESET_BIT    (RESET_LEVEL[i])
        ) u_chan (
            .clk    (clk),
            .n_rst  (n_rst),
            .pin    (pin_in[i]),
            .limit  (debounce_limit),
            .rise_en(rise_en[i]),
            .fall_en(fall_en[i]),
            .clr    (clr[i]),
            .level  (level_out[i]),
            .flag   (event_flags[i])
        );
    end
endmodule
